// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   state_t   : loader FSM states
//   CMD_*     : command byte codes carried in the first byte of a frame
//   is_load_cmd / is_valid_cmd : command classification helpers
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A0,
    A1,
    C0,
    C1,
    DATA,
    WR,
    CSUM
  } state_t;

  localparam logic [7:0] CMD_LOAD_IM = 8'h01;
  localparam logic [7:0] CMD_LOAD_DM = 8'h02;
  localparam logic [7:0] CMD_RUN     = 8'h03;
  localparam logic [7:0] CMD_HALT    = 8'h04;

  function automatic logic is_load_cmd(input logic [7:0] b);
    return (b == CMD_LOAD_IM) || (b == CMD_LOAD_DM);
  endfunction

  function automatic logic is_valid_cmd(input logic [7:0] b);
    return (b >= CMD_LOAD_IM) && (b <= CMD_HALT);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory load port of the program loader.
//   in_valid / in_data / in_ready : byte handshake from the host link
//   addr / din / we_im / we_dm    : word write port into the CPU memories
// master : host link + memory side (drives bytes, observes writes)
// slave  : the loader itself
interface prog_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] addr;
  logic [31:0] din;
  logic        we_im;
  logic        we_dm;

  modport master (
    output in_valid, in_data,
    input  in_ready, addr, din, we_im, we_dm
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, addr, din, we_im, we_dm
  );

endinterface

// File: rtl/loader_timeout.sv
// Idle watchdog for a frame in progress.
//   clk, rstn : clock, async active-low reset
//   clear     : restart the idle count (handshake seen or loader idle)
//   enable    : count this cycle (busy without a handshake)
//   expire    : high in the TIMEOUT_CYC-th consecutive enabled cycle
module loader_timeout #(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  // The count only ever needs to reach TIMEOUT_CYC-1; expire fires while
  // it sits there and another idle cycle is being counted.
  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count;

  assign expire = enable && (count == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader in front of the pipelined CPU.
// Frames: CMD, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, CNT*4 data bytes, CSUM
// (CSUM = XOR of all earlier frame bytes). RUN/HALT are single bytes.
//   clk, rstn     : clock, async active-low reset
//   bus (slave)   : byte handshake in, memory write port out
//   cpu_rstn      : active-low reset to the CPU core (held low until RUN)
//   busy          : a frame is in progress
//   err           : sticky error (bad command, bad checksum, timeout)
//   words_loaded  : words written by the last or current frame
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  prog_loader_if.slave         bus,
  output logic                 cpu_rstn,
  output logic                 busy,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] words_loaded
);

  state_t state, state_next;

  logic                  hs;
  logic                  expire;
  logic                  idle_clear;
  logic                  idle_count;
  logic [7:0]            csum;
  logic [7:0]            addr_lo;
  logic [7:0]            cnt_lo;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [CNT_WIDTH-1:0]  cnt_field;
  logic [1:0]            byte_idx;
  logic [23:0]           shift_word;
  logic [31:0]           din_q;
  logic                  load_is_dm;
  logic                  we_im_q;
  logic                  we_dm_q;

  assign hs         = bus.in_valid && bus.in_ready;
  assign cnt_field  = CNT_WIDTH'({bus.in_data, cnt_lo});
  assign idle_clear = hs || (state == IDLE);
  assign idle_count = (state != IDLE) && !hs;

  assign bus.addr  = 32'(addr_q);
  assign bus.din   = din_q;
  assign bus.we_im = we_im_q;
  assign bus.we_dm = we_dm_q;

  loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .rstn  (rstn),
    .clear (idle_clear),
    .enable(idle_count),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // A timeout overrides whatever the frame would have done next.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (hs && is_load_cmd(bus.in_data)) state_next = A0;
      A0:   if (hs) state_next = A1;
      A1:   if (hs) state_next = C0;
      C0:   if (hs) state_next = C1;
      C1:   if (hs) state_next = (cnt_field == '0) ? CSUM : DATA;
      DATA: if (hs && byte_idx == 2'd3) state_next = WR;
      WR:   state_next = (remaining == CNT_WIDTH'(1)) ? CSUM : DATA;
      CSUM: if (hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (expire) state_next = IDLE;
  end

  // The WR cycle is the only one that refuses a byte, which lets the
  // write bookkeeping happen without colliding with a new data byte.
  always_comb begin
    bus.in_ready = (state != WR);
    busy         = (state != IDLE);
  end

  // Datapath: field capture, word assembly, checksum and status.
  // The write strobe, addr and din are loaded together on the 4th data
  // byte so they are all valid during the WR cycle and addr/din then hold
  // until the next word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_rstn     <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      csum         <= '0;
      addr_lo      <= '0;
      cnt_lo       <= '0;
      word_addr    <= '0;
      addr_q       <= '0;
      remaining    <= '0;
      byte_idx     <= '0;
      shift_word   <= '0;
      din_q        <= '0;
      load_is_dm   <= 1'b0;
      we_im_q      <= 1'b0;
      we_dm_q      <= 1'b0;
    end else begin
      we_im_q <= 1'b0;
      we_dm_q <= 1'b0;
      if (hs) csum <= csum ^ bus.in_data;

      case (state)
        IDLE: begin
          if (hs) begin
            csum <= bus.in_data;
            err  <= !is_valid_cmd(bus.in_data);
            case (bus.in_data)
              CMD_LOAD_IM, CMD_LOAD_DM: begin
                cpu_rstn     <= 1'b0;
                words_loaded <= '0;
                load_is_dm   <= (bus.in_data == CMD_LOAD_DM);
              end
              CMD_RUN:  cpu_rstn <= 1'b1;
              CMD_HALT: cpu_rstn <= 1'b0;
              default: ;
            endcase
          end
        end
        A0: if (hs) addr_lo <= bus.in_data;
        A1: if (hs) word_addr <= ADDR_WIDTH'({bus.in_data, addr_lo});
        C0: if (hs) cnt_lo <= bus.in_data;
        C1: begin
          if (hs) begin
            remaining <= cnt_field;
            byte_idx  <= '0;
          end
        end
        DATA: begin
          if (hs) begin
            byte_idx   <= byte_idx + 2'd1;
            shift_word <= {bus.in_data, shift_word[23:8]};
            if (byte_idx == 2'd3) begin
              din_q   <= {bus.in_data, shift_word};
              addr_q  <= word_addr;
              we_im_q <= !load_is_dm;
              we_dm_q <= load_is_dm;
            end
          end
        end
        WR: begin
          word_addr    <= word_addr + ADDR_WIDTH'(1);
          remaining    <= remaining - CNT_WIDTH'(1);
          words_loaded <= words_loaded + CNT_WIDTH'(1);
        end
        CSUM: if (hs && bus.in_data != csum) err <= 1'b1;
        default: ;
      endcase

      if (expire) err <= 1'b1;
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader sitting upstream of the pipelined CPU top.
- Receives framed bytes from a host link such as a UART receiver, assembles little-endian 32-bit words and writes them into instruction or data memory through the CPU's addr/din/we_im/we_dm load port.
- Owns the CPU core reset, so the core is held in reset while loading and released only on an explicit run command.

Parameters:
- ADDR_WIDTH, 13, width of the word index driven on addr; addr upper bits are zero.
- TIMEOUT_CYC, 65535, idle cycles allowed between bytes mid-frame before the frame is aborted.
- CNT_WIDTH, 16, width of the frame word count and of words_loaded.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
- addr  output  32  memory word index; {0, word_addr[ADDR_WIDTH-1:0]}.
- din  output  32  assembled write word.
- we_im  output  1  one-cycle instruction-memory write strobe.
- we_dm  output  1  one-cycle data-memory write strobe.
- cpu_rstn  output  1  active-low reset to the CPU core.
- busy  output  1  a frame is in progress (state != IDLE).
- err  output  1  sticky error flag.
- words_loaded  output  CNT_WIDTH  words written by the last or current frame.

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0 except in_ready=1.
  - cpu_rstn=0: the core stays held after reset until a RUN command.
- Frame format: CMD, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then CNT×4 data bytes, then CSUM.
  - All multi-byte fields are little-endian; the first data byte maps to din[7:0].
  - CSUM = XOR of every preceding byte in the frame, CMD included.
- Command codes:
  - 0x01 LOAD_IM, 0x02 LOAD_DM: full frame as above.
  - 0x03 RUN, 0x04 HALT: single byte, no further fields.
- States:
  - IDLE→A0→A1→C0→C1→DATA→WR→DATA… →CSUM→IDLE.
  - CNT=0 goes C1→CSUM directly.
- in_ready = (state != WR). Exactly one byte is consumed per handshake cycle.
- DATA:
  - A 2-bit byte index fills a shift word.
  - On the 4th byte, transition to WR.
- WR, one cycle:
  - Assert we_im or we_dm per the latched CMD, with addr=word_addr and din=assembled word.
  - Then word_addr+1 (wraps modulo 2^ADDR_WIDTH, no error), remaining count−1, words_loaded+1.
  - If the count reaches 0 go to CSUM, else DATA.
- Strobe timing: write strobes are registered outputs, high for exactly one cycle per word. addr/din are stable from the strobe cycle until the next strobe.
- CSUM byte:
  - On mismatch set err; otherwise leave err unchanged.
  - Return to IDLE either way. Words already written are not rolled back.
- cpu_rstn transitions:
  - Accepting LOAD_IM or LOAD_DM drives cpu_rstn=0 on the next cycle, even if the core was running.
  - RUN drives cpu_rstn=1 on the next cycle.
  - HALT drives cpu_rstn=0.
  - cpu_rstn changes only on these commands.
- Unknown CMD: set err, stay in IDLE, consume the byte.
- err clears on acceptance of any valid CMD byte (0x01–0x04).
- words_loaded clears when LOAD_IM or LOAD_DM is accepted.
- Timeout:
  - An idle counter resets on every handshake and counts while busy with no handshake.
  - When it reaches TIMEOUT_CYC: go to IDLE, set err, write nothing further. cpu_rstn stays 0.
- Async reset mid-frame: immediate return to reset values, partial word discarded, cpu_rstn=0.
- in_valid with in_ready=0 (WR cycle): the byte is held by the source; nothing is lost.

Decomposition:
- Shared package loader_pkg holds:
  - state enum: IDLE, A0, A1, C0, C1, DATA, WR, CSUM;
  - command localparams CMD_LOAD_IM=8'h01, CMD_LOAD_DM=8'h02, CMD_RUN=8'h03, CMD_HALT=8'h04.
- One sub-module, loader_timeout: the idle counter with clear/enable inputs and an expire output.
- FSM, word assembly and checksum live in prog_loader.

Test Plan:
- Load IM, start 0x0010, CNT 2, words 0x1C000000 and 0x02800404, correct CSUM:
  - two we_im pulses, addr 0x10 then 0x11, din matches;
  - err=0, words_loaded=2, cpu_rstn stays 0.
- RUN then HALT:
  - cpu_rstn=1 one cycle after the RUN handshake;
  - cpu_rstn=0 one cycle after HALT;
  - no write strobes.
- Load DM, start 0x1FFF, CNT 2, wrong CSUM: we_dm at addr 0x1FFF then 0x0000 (wrap), then err=1 after CSUM.
- Frame stalls after 2 data bytes for TIMEOUT_CYC cycles: busy falls, err=1, no strobe; the next 0x01 frame loads normally and clears err.
- Unknown CMD 0x7F: err=1, state IDLE, busy=0.
- LOAD_IM while running: cpu_rstn drops the cycle after the CMD handshake.
- Assert rstn mid-DATA: outputs return to reset values, and a subsequent frame loads correctly.
